// File: rtl/risc_spm_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : risc_spm_control_unit
// Brief    : Fetch/decode/execute sequencer for the 8-bit RISC SPM datapath.
// Revision : 1.0
// ============================================================================
module risc_spm_control_unit #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 zero,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [2:0]           Sel_Bus_1_Mux,
  output logic [1:0]           Sel_Bus_2_Mux,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic                 write,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,  S_FET1 = 4'd1,  S_FET2 = 4'd2, S_DEC  = 4'd3,
    S_EX1  = 4'd4,  S_RD1  = 4'd5,  S_RD2  = 4'd6, S_WR1  = 4'd7,
    S_WR2  = 4'd8,  S_BR1  = 4'd9,  S_BR2  = 4'd10, S_HALT = 4'd11
  } state_t;

  localparam logic [3:0] c_OP_NOP  = 4'd0;
  localparam logic [3:0] c_OP_ADD  = 4'd1;
  localparam logic [3:0] c_OP_SUB  = 4'd2;
  localparam logic [3:0] c_OP_AND  = 4'd3;
  localparam logic [3:0] c_OP_NOT  = 4'd4;
  localparam logic [3:0] c_OP_RD   = 4'd5;
  localparam logic [3:0] c_OP_WR   = 4'd6;
  localparam logic [3:0] c_OP_BR   = 4'd7;
  localparam logic [3:0] c_OP_BRZ  = 4'd8;
  localparam logic [3:0] c_OP_HALT = 4'd15;

  localparam logic [2:0] c_SEL1_PC   = 3'd4;
  localparam logic [1:0] c_SEL2_ALU  = 2'd0;
  localparam logic [1:0] c_SEL2_BUS1 = 2'd1;
  localparam logic [1:0] c_SEL2_MEM  = 2'd2;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_set_illegal;
  logic [3:0] w_load_r;

  logic [3:0] w_opcode;
  logic [1:0] w_src;
  logic [1:0] w_dest;

  assign w_opcode = instruction[WORD_SIZE-1 -: 4];
  assign w_src    = instruction[3:2];
  assign w_dest   = instruction[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = S_IDLE;
    w_set_illegal = 1'b0;
    w_load_r      = 4'b0000;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Sel_Bus_1_Mux = 3'd0;
    Sel_Bus_2_Mux = c_SEL2_ALU;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    write         = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FET1;
      S_FET1: begin
        Sel_Bus_1_Mux = c_SEL1_PC;
        Sel_Bus_2_Mux = c_SEL2_BUS1;
        Load_Add_R    = 1'b1;
        w_next        = S_FET2;
      end
      S_FET2: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        w_next        = S_DEC;
      end
      S_DEC: begin
        case (w_opcode)
          c_OP_NOP: w_next = S_FET1;
          c_OP_ADD, c_OP_SUB, c_OP_AND: begin
            Sel_Bus_1_Mux = {1'b0, w_src};
            Sel_Bus_2_Mux = c_SEL2_BUS1;
            Load_Reg_Y    = 1'b1;
            w_next        = S_EX1;
          end
          c_OP_NOT: begin
            Sel_Bus_1_Mux = {1'b0, w_src};
            Sel_Bus_2_Mux = c_SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            w_load_r      = 4'd1 << w_dest;
            w_next        = S_FET1;
          end
          c_OP_RD, c_OP_WR, c_OP_BR: begin
            Sel_Bus_1_Mux = c_SEL1_PC;
            Sel_Bus_2_Mux = c_SEL2_BUS1;
            Load_Add_R    = 1'b1;
            w_next        = (w_opcode == c_OP_RD) ? S_RD1 :
                            (w_opcode == c_OP_WR) ? S_WR1 : S_BR1;
          end
          c_OP_BRZ: begin
            if (zero) begin
              Sel_Bus_1_Mux = c_SEL1_PC;
              Sel_Bus_2_Mux = c_SEL2_BUS1;
              Load_Add_R    = 1'b1;
              w_next        = S_BR1;
            end else begin
              // Not taken: step the PC over the branch-target byte.
              Inc_PC = 1'b1;
              w_next = S_FET1;
            end
          end
          c_OP_HALT: w_next = S_HALT;
          default: begin
            w_set_illegal = 1'b1;
            w_next        = S_HALT;
          end
        endcase
      end
      S_EX1: begin
        Sel_Bus_1_Mux = {1'b0, w_dest};
        Sel_Bus_2_Mux = c_SEL2_ALU;
        Load_Reg_Z    = 1'b1;
        w_load_r      = 4'd1 << w_dest;
        w_next        = S_FET1;
      end
      S_RD1, S_WR1: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        w_next        = (r_state == S_RD1) ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        w_load_r      = 4'd1 << w_dest;
        w_next        = S_FET1;
      end
      S_WR2: begin
        Sel_Bus_1_Mux = {1'b0, w_src};
        write         = 1'b1;
        w_next        = S_FET1;
      end
      S_BR1: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_Add_R    = 1'b1;
        w_next        = S_BR2;
      end
      S_BR2: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_PC       = 1'b1;
        w_next        = S_FET1;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  assign Load_R0 = w_load_r[0];
  assign Load_R1 = w_load_r[1];
  assign Load_R2 = w_load_r[2];
  assign Load_R3 = w_load_r[3];
  assign illegal = r_illegal;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_risc_spm_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_spm_control_unit
// Brief    : Vector-table bench for the RISC SPM control unit.
// Revision : 1.0
// ============================================================================
module tb_risc_spm_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instruction = 8'h00;
  logic       zero = 1'b0;
  logic       Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  risc_spm_control_unit #(.WORD_SIZE(8)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
    .Load_PC(Load_PC), .Inc_PC(Inc_PC),
    .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
    .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y),
    .Load_Reg_Z(Load_Reg_Z), .write(write), .illegal(illegal), .state(state)
  );

  // Strobe word: {R0,R1,R2,R3,LPC,IPC,SEL1[2:0],SEL2[1:0],LIR,LAR,LRY,LRZ,WR}
  localparam logic [15:0] LPC = 16'h0800, IPC = 16'h0400, LIR = 16'h0010;
  localparam logic [15:0] LAR = 16'h0008, LRY = 16'h0004, LRZ = 16'h0002;
  localparam logic [15:0] WR  = 16'h0001;
  function automatic logic [15:0] LR(input int n);  return 16'h8000 >> n; endfunction
  function automatic logic [15:0] S1(input int v);  return 16'(v) << 7; endfunction
  function automatic logic [15:0] S2(input int v);  return 16'(v) << 5; endfunction

  wire [15:0] act = {Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
                     Sel_Bus_1_Mux, Sel_Bus_2_Mux,
                     Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write};

  typedef struct {
    logic        rst;
    logic [7:0]  instr;
    logic        zero;
    logic [3:0]  st;
    logic        ill;
    logic [15:0] strb;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic        ill;
    logic [15:0] strb;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   applied = 0;
  int   errors  = 0;

  task automatic add(input logic r, input logic [7:0] i, input logic z,
                     input logic [3:0] st, input logic ill, input logic [15:0] strb);
    vec_t v;
    v.rst = r; v.instr = i; v.zero = z; v.st = st; v.ill = ill; v.strb = strb;
    vecs.push_back(v);
  endtask

  task automatic check_invariants(input int idx);
    int nload;
    nload = int'(Load_R0) + int'(Load_R1) + int'(Load_R2) + int'(Load_R3);
    if (Load_PC && Inc_PC) begin
      errors++;
      $display("FAIL pc_exclusive @%0d: Load_PC=%b Inc_PC=%b, required not both 1", idx, Load_PC, Inc_PC);
    end
    if (nload > 1) begin
      errors++;
      $display("FAIL load_r_onehot @%0d: %0d Load_Rn asserted, required <=1", idx, nload);
    end
    if (write && state != 4'd8) begin
      errors++;
      $display("FAIL write_state @%0d: write=1 in state %0d, required only in 8", idx, state);
    end
  endtask

  task automatic measure(input logic [7:0] i, input logic z, input int exp_lat);
    int n;
    instruction = i;
    zero = z;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      check_invariants(1000 + n);
    end while (state != 4'd1 && n < 20);
    applied++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL latency op=%02h zero=%b: got %0d cycles, required %0d", i, z, n, exp_lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset, then ADD R1,R2
    add(1, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h16, 0, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h16, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h16, 0, 3, 0, S1(1) | S2(1) | LRY);
    add(0, 8'h16, 0, 4, 0, S1(2) | S2(0) | LR(2) | LRZ);
    // RD R3
    add(0, 8'h53, 0, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h53, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h53, 0, 3, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h53, 0, 5, 0, S2(2) | LAR | IPC);
    add(0, 8'h53, 0, 6, 0, S2(2) | LR(3));
    // WR src R1
    add(0, 8'h64, 0, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h64, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h64, 0, 3, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h64, 0, 7, 0, S2(2) | LAR | IPC);
    add(0, 8'h64, 0, 8, 0, S1(1) | WR);
    // BRZ not taken, then taken (zero=1 in fetch is don't-care)
    add(0, 8'h80, 1, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h80, 1, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h80, 0, 3, 0, IPC);
    add(0, 8'h80, 1, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h80, 1, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h80, 1, 3, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h80, 1, 9, 0, S2(2) | LAR);
    add(0, 8'h80, 1, 10, 0, S2(2) | LPC);
    // NOT R1 -> R3
    add(0, 8'h47, 0, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h47, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h47, 0, 3, 0, S1(1) | S2(0) | LRZ | LR(3));
    // AND R3,R0
    add(0, 8'h3C, 0, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h3C, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h3C, 0, 3, 0, S1(3) | S2(1) | LRY);
    add(0, 8'h3C, 0, 4, 0, S1(0) | S2(0) | LR(0) | LRZ);
    // Illegal opcode, halt hold, reset out of halt
    add(0, 8'hA0, 0, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'hA0, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'hA0, 0, 3, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 8'h16, k[0], 11, 1, 0);
    add(1, 8'h00, 0, 11, 1, 0);
    add(0, 8'h64, 0, 0, 0, 0);
    // Reset during S_wr1
    add(0, 8'h64, 0, 1, 0, S1(4) | S2(1) | LAR);
    add(0, 8'h64, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'h64, 0, 3, 0, S1(4) | S2(1) | LAR);
    add(1, 8'h64, 0, 7, 0, S2(2) | LAR | IPC);
    add(0, 8'h64, 0, 0, 0, 0);
    add(0, 8'hF0, 0, 1, 0, S1(4) | S2(1) | LAR);
    // HALT opcode: halts without raising illegal
    add(0, 8'hF0, 0, 2, 0, S2(2) | LIR | IPC);
    add(0, 8'hF0, 0, 3, 0, 0);
    add(0, 8'hF0, 0, 11, 0, 0);
    add(0, 8'hF0, 0, 11, 0, 0);

    foreach (vecs[n]) begin
      @(negedge clk);
      rst = vecs[n].rst;
      instruction = vecs[n].instr;
      zero = vecs[n].zero;
      e.st = vecs[n].st; e.ill = vecs[n].ill; e.strb = vecs[n].strb;
      sb.push_back(e);
      #1;
      applied++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard @%0d: queue empty", n);
      end else begin
        e = sb.pop_front();
        if (state !== e.st || illegal !== e.ill || act !== e.strb) begin
          errors++;
          $display("FAIL vec%0d: state=%0d ill=%b strb=%04h, required state=%0d ill=%b strb=%04h",
                   n, state, illegal, act, e.st, e.ill, e.strb);
        end
      end
      check_invariants(n);
    end

    // Latency measurements from S_fet1 back to S_fet1
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    applied++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL latency_start: state=%0d, required 1", state);
    end
    measure(8'h00, 0, 3);
    measure(8'h4B, 0, 3);
    measure(8'h16, 0, 4);
    measure(8'h2E, 0, 4);
    measure(8'h31, 0, 4);
    measure(8'h52, 0, 5);
    measure(8'h61, 0, 5);
    measure(8'h70, 0, 5);
    measure(8'h80, 0, 3);
    measure(8'h80, 1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
`default_nettype wire
